// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the PISO serializer.
// The master modport belongs to the producer/link side; the slave modport belongs to the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter that emits one bit per enabled clock and flags the last bit of each word.
// A new word can load on the final enabled bit, so back-to-back words leave no idle gap.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             last_c;
    logic             ready_c;
    logic             load_hs_c;
    logic [WIDTH-1:0] sreg_shift_c;

    // The shift moves bits toward whichever end feeds ser_out; vacated positions fill with zero.
    assign sreg_shift_c = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    assign last_c    = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    assign ready_c   = !rst && ((state_q == S_IDLE) || (last_c && bus.shift_en));
    assign load_hs_c = bus.load_valid && ready_c;

    // Status outputs come directly from state, so ser_out has no added combinational path.
    assign bus.load_ready = ready_c;
    assign bus.ser_valid  = (state_q == S_SHIFT);
    assign bus.busy       = (state_q == S_SHIFT);
    assign bus.ser_last   = last_c;
    assign bus.ser_out    = (state_q == S_SHIFT) ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0])
                                                 : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // The next state and datapath load only on an enabled bit; a stall holds everything.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_hs_c) begin
                    sreg_d  = bus.load_data;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.shift_en) begin
                    if (last_c) begin
                        cnt_d = '0;
                        if (load_hs_c) begin
                            sreg_d = bus.load_data;
                        end else begin
                            sreg_d  = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        sreg_d = sreg_shift_c;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first instance and an MSB-first instance share the same stimulus.
// Both are compared each cycle against a word/bit-position model, and the collected bit streams are also checked against fixed values.
module tb_piso_serializer;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         shift_en;

    int checks = 0;
    int errors = 0;

    // The model holds the word in flight and the index of the bit currently on the line.
    bit           m_busy;
    logic [W-1:0] m_word;
    int           m_pos;

    logic [31:0] seq0, seq1;
    int          nbits;

    piso_serializer_if #(.WIDTH(W)) if0 ();
    piso_serializer_if #(.WIDTH(W)) if1 ();

    assign if0.load_valid = load_valid;
    assign if0.load_data  = load_data;
    assign if0.shift_en   = shift_en;
    assign if1.load_valid = load_valid;
    assign if1.load_data  = load_data;
    assign if1.shift_en   = shift_en;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(if0));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_seq();
        seq0  = '0;
        seq1  = '0;
        nbits = 0;
    endtask

    // This task checks outputs against the model shortly after a negedge, then advances the model by one posedge.
    task automatic tick();
        logic exp_last, exp_ready, hs;
        #1;
        exp_last  = m_busy && (m_pos == W - 1);
        exp_ready = !rst && (!m_busy || (exp_last && shift_en));
        chk("lsb ser_valid",  32'(if0.ser_valid),  32'(m_busy));
        chk("msb ser_valid",  32'(if1.ser_valid),  32'(m_busy));
        chk("lsb busy",       32'(if0.busy),       32'(m_busy));
        chk("msb busy",       32'(if1.busy),       32'(m_busy));
        chk("lsb ser_last",   32'(if0.ser_last),   32'(exp_last));
        chk("msb ser_last",   32'(if1.ser_last),   32'(exp_last));
        chk("lsb load_ready", 32'(if0.load_ready), 32'(exp_ready));
        chk("msb load_ready", 32'(if1.load_ready), 32'(exp_ready));
        chk("lsb ser_out", 32'(if0.ser_out), m_busy ? 32'(m_word[m_pos]) : 32'd0);
        chk("msb ser_out", 32'(if1.ser_out), m_busy ? 32'(m_word[W - 1 - m_pos]) : 32'd0);
        if (if0.ser_valid && shift_en) begin
            seq0 = {seq0[30:0], if0.ser_out};
            seq1 = {seq1[30:0], if1.ser_out};
            nbits++;
        end
        hs = load_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else begin
            if (m_busy && shift_en) begin
                if (m_pos == W - 1) m_busy = 1'b0;
                else                m_pos++;
            end
            if (hs) begin
                m_busy = 1'b1;
                m_word = load_data;
                m_pos  = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b0;
        m_busy     = 1'b0;
        m_word     = '0;
        m_pos      = 0;
        clr_seq();
        @(posedge clk);
        @(negedge clk);

        // Reset is held for two cycles, then released.
        tick();
        tick();
        chk("reset load_ready low", 32'(if0.load_ready), 32'd0);
        rst = 1'b0;
        tick();

        // 4'b1011 is sent with shift_en held high.
        clr_seq();
        load_valid = 1'b1; load_data = 4'b1011; shift_en = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (5) tick();
        chk("t2 nbits", 32'(nbits), 32'd4);
        chk("t2 lsb sequence", seq0, 32'b1101);
        chk("t3 msb sequence", seq1, 32'b1011);

        // 4'hA and 4'h5 are sent back to back with load_valid held high.
        clr_seq();
        load_valid = 1'b1; load_data = 4'hA;
        tick();
        load_data = 4'h5;
        repeat (4) tick();
        load_valid = 1'b0;
        repeat (5) tick();
        chk("t4 nbits", 32'(nbits), 32'd8);
        chk("t4 lsb sequence", seq0, 32'b01011010);
        chk("t4 msb sequence", seq1, 32'b10100101);

        // 4'b0110 is sent with a three-cycle stall after the first bit.
        clr_seq();
        load_valid = 1'b1; load_data = 4'b0110;
        tick();
        load_valid = 1'b0;
        tick();
        shift_en = 1'b0;
        repeat (3) tick();
        shift_en = 1'b1;
        repeat (4) tick();
        chk("t5 nbits", 32'(nbits), 32'd4);
        chk("t5 lsb sequence", seq0, 32'b0110);
        chk("t5 msb sequence", seq1, 32'b0110);

        // Reset is applied on bit 2 of 4'hF, then 4'h1 is sent.
        load_valid = 1'b1; load_data = 4'hF;
        tick();
        load_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6 post-reset ser_valid", 32'(if0.ser_valid), 32'd0);
        chk("t6 post-reset busy", 32'(if1.busy), 32'd0);
        clr_seq();
        tick();
        load_valid = 1'b1; load_data = 4'h1;
        tick();
        load_valid = 1'b0;
        repeat (5) tick();
        chk("t6 nbits", 32'(nbits), 32'd4);
        chk("t6 lsb sequence", seq0, 32'b1000);
        chk("t6 msb sequence", seq1, 32'b0001);

        // Random traffic with stalls and occasional resets, checked against the model.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = W'($urandom);
            shift_en   = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
